// File: rtl/conv_ctrl_axi_lite_regs.sv
// AXI4-Lite control/status register bank for the 2D convolution filter:
// run/done FSM, double-buffered coefficient channels, sticky done interrupt, frame counter.
module conv_ctrl_axi_lite_regs #(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_CH     = 2,
  parameter int COEF_WIDTH = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [31:0]                  s_axi_wdata,
  input  logic [3:0]                   s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [31:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         tlast,
  output logic                         start,
  output logic                         run,
  output logic                         irq,
  output logic [NUM_CH*COEF_WIDTH-1:0] filter_weights
);
  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [WW-1:0] A_CTRL = WW'(0);
  localparam logic [WW-1:0] A_STAT = WW'(1);
  localparam logic [WW-1:0] A_IRQ  = WW'(2);
  localparam logic [WW-1:0] A_FCNT = WW'(3);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic                                aw_held, w_held;
  logic [WW-1:0]                       aw_idx;
  logic [31:0]                         wdata_q, wmask;
  logic [3:0]                          wstrb_q;
  logic [1:0]                          state, nxt;
  logic                                auto_restart, irq_en, irq_stat;
  logic [31:0]                         frame_cnt;
  logic [NUM_CH-1:0][COEF_WIDTH-1:0]   shadow, weights;
  logic                                commit, wr_map, wr_ctrl, wr_irq;
  logic [NUM_CH-1:0]                   wr_filt;
  logic                                start_wr, abort_wr, done_evt;
  logic [WW-1:0]                       ar_idx;
  logic [31:0]                         rd_data;
  logic                                rd_err;
  logic                                unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];

  // Ready is withheld while a beat is held or a response is pending: one write in flight.
  assign s_axi_awready = !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !w_held && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_rvalid;
  assign commit        = aw_held && w_held && !s_axi_bvalid;
  assign wmask = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

  always_comb begin
    wr_ctrl = (aw_idx == A_CTRL);
    wr_irq  = (aw_idx == A_IRQ);
    wr_filt = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (aw_idx == WW'(4 + c)) wr_filt[c] = 1'b1;
    wr_map = wr_ctrl || wr_irq || (aw_idx == A_STAT) || (aw_idx == A_FCNT) || (|wr_filt);
  end

  assign start_wr = commit && wr_ctrl && wstrb_q[0] && wdata_q[0];
  assign abort_wr = commit && wr_ctrl && wstrb_q[0] && wdata_q[3];
  assign done_evt = (state == S_RUN) && tlast && !abort_wr;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start_wr) nxt = S_RUN;
      S_RUN:   if (tlast) nxt = S_DONE;
      S_DONE:  if (start_wr || auto_restart) nxt = S_RUN;
      default: nxt = S_IDLE;
    endcase
    if (abort_wr) nxt = S_IDLE;
  end

  always_comb begin
    rd_data = 32'd0;
    rd_err  = 1'b0;
    case (ar_idx)
      A_CTRL: rd_data = {28'd0, 1'b0, irq_en, auto_restart, 1'b0};
      A_STAT: rd_data = {30'd0, state};
      A_IRQ:  rd_data = {31'd0, irq_stat};
      A_FCNT: rd_data = frame_cnt;
      default: begin
        rd_err = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
          if (ar_idx == WW'(4 + c)) begin
            rd_data = 32'(shadow[c]);
            rd_err  = 1'b0;
          end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held <= 1'b0; w_held <= 1'b0; aw_idx <= '0; wdata_q <= '0; wstrb_q <= '0;
      s_axi_bvalid <= 1'b0; s_axi_bresp <= OKAY;
      s_axi_rvalid <= 1'b0; s_axi_rdata <= '0; s_axi_rresp <= OKAY;
      state <= S_IDLE; auto_restart <= 1'b0; irq_en <= 1'b0; irq_stat <= 1'b0;
      frame_cnt <= '0; shadow <= '0; weights <= '0; start <= 1'b0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_map ? OKAY : SLVERR;
        if (wr_ctrl && wstrb_q[0]) begin
          auto_restart <= wdata_q[1];
          irq_en       <= wdata_q[2];
        end
        for (int c = 0; c < NUM_CH; c++)
          if (wr_filt[c])
            shadow[c] <= COEF_WIDTH'((32'(shadow[c]) & ~wmask) | (wdata_q & wmask));
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      // A completing frame outranks a same-cycle W1C so no done event is lost.
      if (done_evt) irq_stat <= 1'b1;
      else if (commit && wr_irq && wstrb_q[0] && wdata_q[0]) irq_stat <= 1'b0;
      if (done_evt) frame_cnt <= frame_cnt + 32'd1;
      state <= nxt;
      start <= (nxt == S_RUN) && (state != S_RUN);
      if ((nxt == S_RUN) && (state != S_RUN)) weights <= shadow;
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_err ? SLVERR : OKAY;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  assign run            = (state == S_RUN);
  assign irq            = irq_stat && irq_en;
  assign filter_weights = weights;
endmodule
